// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the LEGv8 pipeline.
// Holds the PC, addresses the instruction ROM and fills the IF/ID register.
// Redirect priority: exc_i > eret_i > branch_i > stall_i > sequential PC+4.
// Optional feature macro: FETCH_FAULT_EN. When it is defined, misaligned or
// out-of-ROM PCs raise a fetch fault and park the FSM in HALT. When it is
// undefined, no fault is ever raised and the PC aliases into the ROM.
//
// state | meaning
// RUN   | normal fetch, one instruction per non-stalled edge
// HALT  | fetch fault taken; PC frozen, bubbles until exc_i or eret_i
module fetch_unit #(
    parameter int          N           = 64,
    parameter logic [N-1:0] VECTOR_ADDR = 64'hD4,
    parameter int          AW          = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_i,
    input  logic          branch_i,
    input  logic [N-1:0]  branch_target_i,
    input  logic          exc_i,
    input  logic          eret_i,
    input  logic [N-1:0]  elr_i,
    output logic [AW-1:0] imem_addr_o,
    input  logic [31:0]   imem_q_i,
    output logic [N-1:0]  ifid_pc_o,
    output logic [31:0]   ifid_instr_o,
    output logic          ifid_valid_o,
    output logic          ifid_fault_o
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  pc, pc_nxt;
    logic [N-1:0]  ifid_pc_nxt;
    logic [31:0]   ifid_instr_nxt;
    logic          ifid_valid_nxt;
    logic          ifid_fault_nxt;
    logic          fault_det;
    logic          branch_eff;

`ifdef FETCH_FAULT_EN
    assign fault_det = (pc[1:0] != 2'b00) || (pc[N-1:AW+2] != '0);
`else
    assign fault_det = 1'b0;
`endif

    // Branches are only honoured while fetching; a halted fetch ignores them.
    assign branch_eff  = branch_i && (state == RUN);
    assign imem_addr_o = pc[AW+1:2];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    // Next-state: exceptions/returns always resume fetch; a fault on a
    // sequential edge parks the FSM. An exception in the same cycle wins.
    always_comb begin
        state_nxt = state;
        if (exc_i || eret_i) begin
            state_nxt = RUN;
        end else if (state == RUN && !branch_i && !stall_i && fault_det) begin
            state_nxt = HALT;
        end
    end

    // Output/datapath next values: PC and IF/ID contents for the coming edge.
    always_comb begin
        pc_nxt         = pc;
        ifid_pc_nxt    = ifid_pc_o;
        ifid_instr_nxt = ifid_instr_o;
        ifid_valid_nxt = ifid_valid_o;
        ifid_fault_nxt = ifid_fault_o;
        if (exc_i || eret_i || branch_eff) begin
            if (exc_i)       pc_nxt = VECTOR_ADDR;
            else if (eret_i) pc_nxt = elr_i;
            else             pc_nxt = branch_target_i;
            ifid_pc_nxt    = '0;
            ifid_instr_nxt = 32'h0;
            ifid_valid_nxt = 1'b0;
            ifid_fault_nxt = 1'b0;
        end else if (stall_i) begin
            pc_nxt = pc;
        end else if (state == HALT) begin
            ifid_pc_nxt    = '0;
            ifid_instr_nxt = 32'h0;
            ifid_valid_nxt = 1'b0;
            ifid_fault_nxt = 1'b0;
        end else if (fault_det) begin
            ifid_pc_nxt    = pc;
            ifid_instr_nxt = 32'h0;
            ifid_valid_nxt = 1'b0;
            ifid_fault_nxt = 1'b1;
        end else begin
            pc_nxt         = pc + N'(4);
            ifid_pc_nxt    = pc;
            ifid_instr_nxt = imem_q_i;
            ifid_valid_nxt = 1'b1;
            ifid_fault_nxt = 1'b0;
        end
    end

    // PC and IF/ID pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= '0;
            ifid_pc_o    <= '0;
            ifid_instr_o <= 32'h0;
            ifid_valid_o <= 1'b0;
            ifid_fault_o <= 1'b0;
        end else begin
            pc           <= pc_nxt;
            ifid_pc_o    <= ifid_pc_nxt;
            ifid_instr_o <= ifid_instr_nxt;
            ifid_valid_o <= ifid_valid_nxt;
            ifid_fault_o <= ifid_fault_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed sequences, a vector table and a
// randomized run against a behavioural fetch model.
module tb_fetch_unit;

`ifdef FETCH_FAULT_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall_i, branch_i, exc_i, eret_i;
    logic [63:0] branch_target_i, elr_i;
    logic [6:0]  imem_addr_o;
    logic [31:0] imem_q_i;
    logic [63:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o, ifid_fault_o;

    logic [31:0] rom [128];
    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [63:0] m_pc;
    logic        m_halt;
    logic [63:0] m_ipc;
    logic [31:0] m_instr;
    logic        m_valid, m_fault;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .branch_i(branch_i),
        .branch_target_i(branch_target_i), .exc_i(exc_i), .eret_i(eret_i),
        .elr_i(elr_i), .imem_addr_o(imem_addr_o), .imem_q_i(imem_q_i),
        .ifid_pc_o(ifid_pc_o), .ifid_instr_o(ifid_instr_o),
        .ifid_valid_o(ifid_valid_o), .ifid_fault_o(ifid_fault_o)
    );

    assign imem_q_i = rom[imem_addr_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall_i = 0; branch_i = 0; exc_i = 0; eret_i = 0;
        branch_target_i = '0; elr_i = '0;
    endtask

    task automatic model_reset();
        m_pc = '0; m_halt = 0; m_ipc = '0; m_instr = '0; m_valid = 0; m_fault = 0;
    endtask

    task automatic model_flush();
        m_ipc = '0; m_instr = '0; m_valid = 0; m_fault = 0;
    endtask

    // One clock edge of the fetch stage, from the priority rules.
    task automatic model_step();
        if (exc_i) begin
            m_pc = 64'hD4; model_flush(); m_halt = 0;
        end else if (eret_i) begin
            m_pc = elr_i; model_flush(); m_halt = 0;
        end else if (branch_i && !m_halt) begin
            m_pc = branch_target_i; model_flush();
        end else if (stall_i) begin
            // hold everything
        end else if (m_halt) begin
            model_flush();
        end else if (FE && ((m_pc % 4) != 0 || m_pc >= 64'd512)) begin
            m_ipc = m_pc; m_instr = '0; m_valid = 0; m_fault = 1; m_halt = 1;
        end else begin
            m_ipc = m_pc; m_instr = rom[(m_pc / 4) % 128]; m_valid = 1; m_fault = 0;
            m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        reset = 0;
        model_reset();
        #2;
        @(negedge clk);
        reset = 1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_addr"},  {57'd0, imem_addr_o}, (m_pc / 4) % 128);
        check({tag, "_valid"}, {63'd0, ifid_valid_o}, {63'd0, m_valid});
        check({tag, "_fault"}, {63'd0, ifid_fault_o}, {63'd0, m_fault});
        check({tag, "_instr"}, {32'd0, ifid_instr_o}, {32'd0, m_instr});
        if (m_valid || m_fault) check({tag, "_pc"}, ifid_pc_o, m_ipc);
    endtask

    typedef struct {
        logic        stall, branch, exc, eret;
        logic [63:0] tgt, elr;
        logic [63:0] e_pc;
        logic        e_valid;
        logic [6:0]  e_addr;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{0,0,0,0, 64'h0,   64'h0,    64'h0,  1, 7'h01};
        tbl[1] = '{1,0,0,0, 64'h0,   64'h0,    64'h0,  1, 7'h01};
        tbl[2] = '{0,1,0,0, 64'h40,  64'h0,    64'h0,  0, 7'h10};
        tbl[3] = '{0,0,0,0, 64'h0,   64'h0,    64'h40, 1, 7'h11};
        tbl[4] = '{1,1,1,0, 64'h80,  64'h0,    64'h0,  0, 7'h35};
        tbl[5] = '{0,0,0,0, 64'h0,   64'h0,    64'hD4, 1, 7'h36};
        tbl[6] = '{0,1,0,1, 64'h20,  64'h100,  64'h0,  0, 7'h40};
        tbl[7] = '{1,1,0,0, 64'h20,  64'h0,    64'h0,  0, 7'h08};
        tbl[8] = '{0,0,0,0, 64'h0,   64'h0,    64'h20, 1, 7'h09};
        tbl[9] = '{0,0,0,0, 64'h0,   64'h0,    64'h24, 1, 7'h0A};

        for (int i = 0; i < 128; i++) rom[i] = 32'hA000_0000 + i * 32'h0001_0103;
        for (int i = 0; i < 14; i++) rom[i] = 32'h8b030041;
        rom[53] = 32'h8b010062;

        reset = 0;
        idle();
        model_reset();
        #3;
        check("rst_pc",    ifid_pc_o, 64'h0);
        check("rst_instr", {32'd0, ifid_instr_o}, 64'h0);
        check("rst_valid", {63'd0, ifid_valid_o}, 64'h0);
        check("rst_fault", {63'd0, ifid_fault_o}, 64'h0);
        check("rst_addr",  {57'd0, imem_addr_o}, 64'h0);
        @(negedge clk);
        reset = 1;

        // reset release: words 0,4,8 captured back to back
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq_pc",    ifid_pc_o, 64'(i * 4));
            check("seq_instr", {32'd0, ifid_instr_o}, 64'h8b030041);
            check("seq_valid", {63'd0, ifid_valid_o}, 64'h1);
        end

        // stall at PC=8
        do_reset();
        tick(); tick();
        stall_i = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_addr", {57'd0, imem_addr_o}, 64'h2);
            check("stall_pc",   ifid_pc_o, 64'h4);
        end
        stall_i = 0;
        tick();
        check("unstall_pc",    ifid_pc_o, 64'h8);
        check("unstall_valid", {63'd0, ifid_valid_o}, 64'h1);

        // exception at PC=0x20
        branch_i = 1; branch_target_i = 64'h20;
        tick();
        idle();
        check("br_addr", {57'd0, imem_addr_o}, 64'h8);
        exc_i = 1;
        tick();
        idle();
        check("exc_flush_valid", {63'd0, ifid_valid_o}, 64'h0);
        check("exc_flush_instr", {32'd0, ifid_instr_o}, 64'h0);
        check("exc_flush_pc",    ifid_pc_o, 64'h0);
        tick();
        check("exc_vec_pc",    ifid_pc_o, 64'hD4);
        check("exc_vec_instr", {32'd0, ifid_instr_o}, 64'h8b010062);
        check("exc_vec_valid", {63'd0, ifid_valid_o}, 64'h1);

        // exc + branch + stall together: exception wins
        exc_i = 1; branch_i = 1; branch_target_i = 64'h40; stall_i = 1;
        tick();
        idle();
        check("exc_prio_addr", {57'd0, imem_addr_o}, 64'h35);
        tick();
        check("exc_prio_pc", ifid_pc_o, 64'hD4);

        // misaligned branch target
        branch_i = 1; branch_target_i = 64'h202;
        tick();
        idle();
        check("mis_addr", {57'd0, imem_addr_o}, 64'h0);
        tick();
`ifdef FETCH_FAULT_EN
        check("mis_fault",  {63'd0, ifid_fault_o}, 64'h1);
        check("mis_pc",     ifid_pc_o, 64'h202);
        check("mis_valid",  {63'd0, ifid_valid_o}, 64'h0);
        branch_i = 1; branch_target_i = 64'h40;
        tick();
        idle();
        check("halt_fault", {63'd0, ifid_fault_o}, 64'h0);
        check("halt_valid", {63'd0, ifid_valid_o}, 64'h0);
        check("halt_addr",  {57'd0, imem_addr_o}, 64'h0);
        tick();
        check("halt2_valid", {63'd0, ifid_valid_o}, 64'h0);
        eret_i = 1; elr_i = 64'h10;
        tick();
        idle();
        check("eret_flush_valid", {63'd0, ifid_valid_o}, 64'h0);
        tick();
        check("eret_pc",    ifid_pc_o, 64'h10);
        check("eret_valid", {63'd0, ifid_valid_o}, 64'h1);
`else
        check("mis_fault", {63'd0, ifid_fault_o}, 64'h0);
        check("mis_pc",    ifid_pc_o, 64'h202);
        check("mis_instr", {32'd0, ifid_instr_o}, {32'd0, rom[0]});
        check("mis_valid", {63'd0, ifid_valid_o}, 64'h1);
`endif

        // vector table from reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            stall_i = tbl[i].stall; branch_i = tbl[i].branch;
            exc_i = tbl[i].exc; eret_i = tbl[i].eret;
            branch_target_i = tbl[i].tgt; elr_i = tbl[i].elr;
            tick();
            check($sformatf("tbl%0d_pc", i), ifid_pc_o, tbl[i].e_pc);
            check($sformatf("tbl%0d_valid", i), {63'd0, ifid_valid_o}, {63'd0, tbl[i].e_valid});
            check($sformatf("tbl%0d_addr", i), {57'd0, imem_addr_o}, {57'd0, tbl[i].e_addr});
            check($sformatf("tbl%0d_instr", i), {32'd0, ifid_instr_o},
                  tbl[i].e_valid ? {32'd0, rom[tbl[i].e_pc[8:2]]} : 64'h0);
        end
        idle();

        // randomized run against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            int r;
            stall_i  = ($urandom_range(0, 99) < 25);
            branch_i = ($urandom_range(0, 99) < 15);
            exc_i    = ($urandom_range(0, 99) < 3);
            eret_i   = ($urandom_range(0, 99) < 4);
            r = $urandom_range(0, 9);
            if (r < 7)       branch_target_i = {55'd0, 7'($urandom_range(0, 127)), 2'b00};
            else if (r == 7) branch_target_i = 64'($urandom_range(0, 1023));
            else if (r == 8) branch_target_i = 64'hFFFF_FFFF_FFFF_FFF8;
            else             branch_target_i = {$urandom, $urandom};
            elr_i = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 1023))
                                                : {55'd0, 7'($urandom_range(0, 127)), 2'b00};
            tick();
            compare_model("rnd");
        end

        // asynchronous reset mid-operation
        idle();
        tick();
        #2;
        reset = 0;
        #1;
        check("arst_pc",    ifid_pc_o, 64'h0);
        check("arst_valid", {63'd0, ifid_valid_o}, 64'h0);
        check("arst_fault", {63'd0, ifid_fault_o}, 64'h0);
        check("arst_instr", {32'd0, ifid_instr_o}, 64'h0);
        check("arst_addr",  {57'd0, imem_addr_o}, 64'h0);
        model_reset();
        @(negedge clk);
        reset = 1;
        tick();
        compare_model("post_arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined LEGv8 core. Holds the PC and drives the word address of the instruction ROM (`imem`). Captures the returned word into the IF/ID pipeline register. Handles stall, branch redirect, exception redirect to the fixed exception vector, ERET return, and fetch-fault detection.

## Interface
Parameters:
- `N`, 64, datapath/PC width.
- `VECTOR_ADDR`, 64'hD4, byte address of the exception vector (ROM word 53).
- `AW`, 7, ROM word-address width.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall_i`  in  1  hold PC and IF/ID (hazard unit).
- `branch_i`  in  1  taken branch resolved downstream.
- `branch_target_i`  in  N  branch target byte address.
- `exc_i`  in  1  exception taken downstream; redirect to `VECTOR_ADDR`.
- `eret_i`  in  1  exception return.
- `elr_i`  in  N  return byte address for `eret_i`.
- `imem_addr_o`  out  AW  ROM word address = PC[AW+1:2].
- `imem_q_i`  in  32  ROM data (combinational read).
- `ifid_pc_o`  out  N  PC of the instruction in IF/ID.
- `ifid_instr_o`  out  32  instruction in IF/ID. 32'h0 when it is a bubble.
- `ifid_valid_o`  out  1  IF/ID holds a real instruction.
- `ifid_fault_o`  out  1  IF/ID entry is a fetch fault, not an instruction.

## Operation
- PC is a registered byte address. `imem_addr_o` is combinational from PC.
- Redirect priority, highest first: `exc_i` > `eret_i` > `branch_i` > `stall_i` > sequential PC+4.
  - `exc_i`: next PC = `VECTOR_ADDR`.
  - `eret_i`: next PC = `elr_i`.
  - `branch_i`: next PC = `branch_target_i`.
- Any redirect overrides `stall_i` and flushes IF/ID on the same edge: valid=0, fault=0, instr=0, pc=0.
- `stall_i` alone: PC and IF/ID hold their values.
- Sequential edge: IF/ID <= {PC, `imem_q_i`, valid=1}. PC <= PC+4, wrapping modulo 2^N.
- Fault detection: PC[1:0]≠0, or PC[N-1:AW+2]≠0 (outside the 128-word ROM).
  - On a sequential edge with a fault: IF/ID <= {PC, 32'h0, valid=0, fault=1}.
  - PC holds and the FSM enters HALT.
- FSM states:
  - RUN: normal fetch.
  - HALT: PC frozen. Each non-stalled edge loads IF/ID with a bubble (valid=0, fault=0). Stays in HALT until `exc_i` or `eret_i`, which apply their redirect and return to RUN. `branch_i` in HALT is ignored.
- Simultaneous `exc_i` and fault: the exception wins. No fault is recorded and the FSM goes to RUN.

## Timing
- Reset (async assert): PC=0, state RUN. `ifid_pc_o`=0, `ifid_instr_o`=0, `ifid_valid_o`=0, `ifid_fault_o`=0. `imem_addr_o`=0.
- Deassertion: the first rising edge captures ROM word 0 into IF/ID.
- Latency:
  - PC to IF/ID: 1 cycle.
  - Redirect to first valid IF/ID entry from the new target: 2 edges. The first edge flushes, the second captures the target.
- Throughput: one instruction per cycle while RUN and not stalled.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of `clk`.

## Configuration
- `FETCH_FAULT_EN` defined:
  - Fault detection and the HALT state are present as described.
- `FETCH_FAULT_EN` undefined:
  - No range or alignment check. `imem_addr_o` is still PC[AW+1:2], so out-of-range PCs alias into the ROM.
  - `ifid_fault_o` is tied 0 and the FSM stays in RUN.

## Test plan
- Reset release with ROM words 0–13 = 32'h8b030041: over 3 edges IF/ID shows pc 0, 4, 8, each with instr 32'h8b030041 and valid=1.
- `stall_i`=1 for 2 cycles at PC=8: `imem_addr_o` stays 2 and IF/ID stays pc=4. On release, sequential fetch resumes at pc=8.
- `exc_i` pulse while PC=0x20: next edge flushes IF/ID (valid=0, instr 0). The edge after captures pc=0xD4, instr 32'h8b010062.
- Same cycle `exc_i`=1, `branch_i`=1 (target 0x40), `stall_i`=1: the exception wins and PC becomes 0xD4.
- `branch_i` to 0x202 (misaligned) with `FETCH_FAULT_EN` defined: IF/ID gets fault=1, pc=0x202. Bubbles follow and PC is held. `eret_i` with `elr_i`=0x10 then gives pc=0x10 valid two edges later.
- Same 0x202 branch with `FETCH_FAULT_EN` undefined: `imem_addr_o`=0, so IF/ID captures ROM word 0 with valid=1 and `ifid_fault_o` stays 0.
